pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
Gameplay sequencer for the pong datapath. It owns the ball's direction and the serve/point/game-over state machine, and it keeps both scores. Once per frame it decides whether the ball moves, bounces, scores or is re-served. It sits between the collision detectors and the ball position registers and is advanced by the frame tick (vsync falling edge).

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
BALL_SIZE, 8, ball edge length in pixels
WALL_MARGIN, 8, pixel band at top and bottom where a bounce triggers
PAUSE_FRAMES, 60, frames held in POINT before the re-serve
WIN_SCORE, 9, score that ends the game (at most 15)

Ports:
clk  input  1  system clock (pixel clock)
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle pulse per frame; all state updates occur only on cycles where it is high
p1_srv  input  1  player 1 serve button, level, sampled on frame_tick
p2_srv  input  1  player 2 serve button, level, sampled on frame_tick
p1_hit  input  1  ball overlaps paddle 1, level
p2_hit  input  1  ball overlaps paddle 2, level
ball_x  input  10  current ball x (left edge)
ball_y  input  9  current ball y (top edge)
ball_dx  output  2  signed x direction: +1, -1 or 0
ball_dy  output  2  signed y direction: +1, -1 or 0
move_en  output  1  one-cycle pulse; the position registers add the directions this cycle
ball_load  output  1  one-cycle pulse; the position registers load the serve position for serve_side
serve_side  output  1  0 = right player serves, 1 = left player serves
score1  output  4  player 1 score
score2  output  4  player 2 score
state  output  3  current FSM state, for debug and display

Behaviour:
- Reset (asynchronous, any time, including mid-rally):
  - state=SERVE, serve_side=0, dx=0, dy=0, scores=0, pause counter=0.
  - move_en=0, ball_load=0, dy_seed=0.
  - The outputs are registered and the pulses are flopped.
- State encoding: SERVE=0, PLAY=1, POINT=2, OVER=3; codes 4-7 recover to SERVE on the next tick.
- dy_seed: a 1-bit register that toggles on every frame_tick.
- All transitions happen on frame_tick cycles only. Each pulse output is high for the single cycle after the deciding tick (latency 1).
- SERVE:
  - Ball is held: dx=dy=0, no move_en.
  - Serve request: serve_side=1 with p1_srv, or serve_side=0 with p2_srv.
  - On a serve request: dx=+1 if serve_side=1, else -1; dy=+1 if dy_seed=1, else -1. Go to PLAY.
  - The wrong player's button is ignored.
- PLAY: every tick pulses move_en, then applies the following in order.
  - Miss left: ball_x < WALL_MARGIN and p1_hit=0 → score2+1, serve_side=1, go to POINT.
  - Miss right: ball_x >= SCREEN_W-BALL_SIZE-WALL_MARGIN and p2_hit=0 → score1+1, serve_side=0, go to POINT.
  - A move_en is still issued on the tick that detects a miss.
  - Paddle hits: p1_hit → dx=+1; else p2_hit → dx=-1. A hit always overrides a miss at the same x.
  - Walls: ball_y <= WALL_MARGIN and dy=-1 → dy=+1. ball_y >= SCREEN_H-BALL_SIZE-WALL_MARGIN and dy=+1 → dy=-1.
  - Wall and paddle updates apply on the same tick when both occur; direction changes take effect from the next move_en.
- POINT:
  - dx=dy=0, no move_en.
  - Pause counter counts ticks from 0.
  - When the count reaches PAUSE_FRAMES-1: if either score equals WIN_SCORE go to OVER; else pulse ball_load, clear the counter, go to SERVE.
- OVER:
  - Scores are frozen.
  - p1_srv or p2_srv on a tick → scores=0, serve_side=0, pulse ball_load, go to SERVE.
- Score arithmetic: 4-bit saturating at WIN_SCORE; never wraps.
- Both srv buttons in OVER: one restart. Both hits asserted at once: p1_hit wins.

Test Plan:
- Reset → state=0, serve_side=0, scores 0/0, dx=dy=0. Then p1_srv on a tick → no change. Then p2_srv on a tick → state=1, dx=-1, move_en pulses on each following tick.
- PLAY with dx=-1, ball_x=5, p1_hit=1 → dx=+1, no score change. Same with p1_hit=0 → score2=1, serve_side=1, state=2.
- POINT → exactly 60 ticks then ball_load pulses once and state=0. Then p1_srv → dx=+1.
- dy=-1, ball_y=8 and p2_hit=1 on the same tick → dy=+1 and dx=-1 simultaneously.
- score1=8, right miss → score1=9; after 60 ticks state=3, no ball_load. Then p2_srv → scores 0/0, state=0, ball_load pulses.
- Assert rst_n low in PLAY between ticks → outputs reach reset values immediately, with no clk edge needed.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong gameplay sequencer: owns ball direction, the serve/play/point/over FSM and both scores.
// Every state change is qualified by i_frame_tick; all outputs come straight from flops.
module pong_game_ctrl #(
   parameter int unsigned SCREEN_W     = 640,
   parameter int unsigned SCREEN_H     = 480,
   parameter int unsigned BALL_SIZE    = 8,
   parameter int unsigned WALL_MARGIN  = 8,
   parameter int unsigned PAUSE_FRAMES = 60,
   parameter int unsigned WIN_SCORE    = 9
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_frame_tick,
   input  logic       i_p1_srv,
   input  logic       i_p2_srv,
   input  logic       i_p1_hit,
   input  logic       i_p2_hit,
   input  logic [9:0] i_ball_x,
   input  logic [8:0] i_ball_y,
   output logic [1:0] o_ball_dx,
   output logic [1:0] o_ball_dy,
   output logic       o_move_en,
   output logic       o_ball_load,
   output logic       o_serve_side,
   output logic [3:0] o_score1,
   output logic [3:0] o_score2,
   output logic [2:0] o_state
);

   typedef enum logic [2:0] {
      StServe = 3'd0,
      StPlay  = 3'd1,
      StPoint = 3'd2,
      StOver  = 3'd3
   } state_t;

   // Two's complement direction codes on a 2-bit bus
   localparam logic [1:0] DirZero = 2'b00;
   localparam logic [1:0] DirPos  = 2'b01;
   localparam logic [1:0] DirNeg  = 2'b11;

   localparam int unsigned CntW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

   localparam logic [9:0]      XLeftLim  = 10'(WALL_MARGIN);
   localparam logic [9:0]      XRightLim = 10'(SCREEN_W - BALL_SIZE - WALL_MARGIN);
   localparam logic [8:0]      YTopLim   = 9'(WALL_MARGIN);
   localparam logic [8:0]      YBotLim   = 9'(SCREEN_H - BALL_SIZE - WALL_MARGIN);
   localparam logic [3:0]      WinScore  = 4'(WIN_SCORE);
   localparam logic [CntW-1:0] CntLast   = CntW'(PAUSE_FRAMES - 1);

   // Registered state and outputs
   state_t          r_state;
   logic [1:0]      r_dx;
   logic [1:0]      r_dy;
   logic            r_move_en;
   logic            r_ball_load;
   logic            r_serve_side;
   logic [3:0]      r_score1;
   logic [3:0]      r_score2;
   logic [CntW-1:0] r_pause_cnt;
   logic            r_dy_seed;

   // Next-state values
   state_t          w_state_nxt;
   logic [1:0]      w_dx_nxt;
   logic [1:0]      w_dy_nxt;
   logic            w_move_en_nxt;
   logic            w_ball_load_nxt;
   logic            w_serve_side_nxt;
   logic [3:0]      w_score1_nxt;
   logic [3:0]      w_score2_nxt;
   logic [CntW-1:0] w_pause_cnt_nxt;
   logic            w_dy_seed_nxt;

   // Decoded conditions
   logic w_srv_req;
   logic w_miss_left;
   logic w_miss_right;
   logic w_wall_top;
   logic w_wall_bot;
   logic w_game_won;

   // Score increment that sticks at the winning score instead of wrapping
   function automatic logic [3:0] sat_inc(input logic [3:0] score);
      return (score >= WinScore) ? score : score + 4'd1;
   endfunction

   // Only the player whose turn it is may serve; a paddle overlap cancels a miss
   always_comb begin
      w_srv_req    = r_serve_side ? i_p1_srv : i_p2_srv;
      w_miss_left  = (i_ball_x < XLeftLim) && !i_p1_hit;
      w_miss_right = (i_ball_x >= XRightLim) && !i_p2_hit;
      w_wall_top   = (i_ball_y <= YTopLim) && (r_dy == DirNeg);
      w_wall_bot   = (i_ball_y >= YBotLim) && (r_dy == DirPos);
      w_game_won   = (r_score1 == WinScore) || (r_score2 == WinScore);
   end

   // Next-state and next-output logic; everything holds unless a frame tick is present
   always_comb begin
      w_state_nxt      = r_state;
      w_dx_nxt         = r_dx;
      w_dy_nxt         = r_dy;
      w_move_en_nxt    = 1'b0;
      w_ball_load_nxt  = 1'b0;
      w_serve_side_nxt = r_serve_side;
      w_score1_nxt     = r_score1;
      w_score2_nxt     = r_score2;
      w_pause_cnt_nxt  = r_pause_cnt;
      w_dy_seed_nxt    = r_dy_seed;

      if (i_frame_tick) begin
         w_dy_seed_nxt = ~r_dy_seed;

         case (r_state)
            StServe: begin
               w_dx_nxt = DirZero;
               w_dy_nxt = DirZero;
               if (w_srv_req) begin
                  w_dx_nxt    = r_serve_side ? DirPos : DirNeg;
                  w_dy_nxt    = r_dy_seed ? DirPos : DirNeg;
                  w_state_nxt = StPlay;
               end
            end

            StPlay: begin
               // The ball still steps on the tick that detects a miss
               w_move_en_nxt = 1'b1;
               if (w_miss_left) begin
                  w_score2_nxt     = sat_inc(r_score2);
                  w_serve_side_nxt = 1'b1;
                  w_dx_nxt         = DirZero;
                  w_dy_nxt         = DirZero;
                  w_pause_cnt_nxt  = '0;
                  w_state_nxt      = StPoint;
               end else if (w_miss_right) begin
                  w_score1_nxt     = sat_inc(r_score1);
                  w_serve_side_nxt = 1'b0;
                  w_dx_nxt         = DirZero;
                  w_dy_nxt         = DirZero;
                  w_pause_cnt_nxt  = '0;
                  w_state_nxt      = StPoint;
               end else begin
                  if (i_p1_hit) begin
                     w_dx_nxt = DirPos;
                  end else if (i_p2_hit) begin
                     w_dx_nxt = DirNeg;
                  end
                  if (w_wall_top) begin
                     w_dy_nxt = DirPos;
                  end else if (w_wall_bot) begin
                     w_dy_nxt = DirNeg;
                  end
               end
            end

            StPoint: begin
               w_dx_nxt = DirZero;
               w_dy_nxt = DirZero;
               if (r_pause_cnt == CntLast) begin
                  w_pause_cnt_nxt = '0;
                  if (w_game_won) begin
                     w_state_nxt = StOver;
                  end else begin
                     w_ball_load_nxt = 1'b1;
                     w_state_nxt     = StServe;
                  end
               end else begin
                  w_pause_cnt_nxt = r_pause_cnt + 1'b1;
               end
            end

            StOver: begin
               w_dx_nxt = DirZero;
               w_dy_nxt = DirZero;
               if (i_p1_srv || i_p2_srv) begin
                  w_score1_nxt     = 4'd0;
                  w_score2_nxt     = 4'd0;
                  w_serve_side_nxt = 1'b0;
                  w_ball_load_nxt  = 1'b1;
                  w_pause_cnt_nxt  = '0;
                  w_state_nxt      = StServe;
               end
            end

            // Unused encodings fall back to a held serve
            default: begin
               w_dx_nxt        = DirZero;
               w_dy_nxt        = DirZero;
               w_pause_cnt_nxt = '0;
               w_state_nxt     = StServe;
            end
         endcase
      end
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StServe;
         r_dx         <= DirZero;
         r_dy         <= DirZero;
         r_move_en    <= 1'b0;
         r_ball_load  <= 1'b0;
         r_serve_side <= 1'b0;
         r_score1     <= 4'd0;
         r_score2     <= 4'd0;
         r_pause_cnt  <= '0;
         r_dy_seed    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_dx         <= w_dx_nxt;
         r_dy         <= w_dy_nxt;
         r_move_en    <= w_move_en_nxt;
         r_ball_load  <= w_ball_load_nxt;
         r_serve_side <= w_serve_side_nxt;
         r_score1     <= w_score1_nxt;
         r_score2     <= w_score2_nxt;
         r_pause_cnt  <= w_pause_cnt_nxt;
         r_dy_seed    <= w_dy_seed_nxt;
      end
   end

   assign o_ball_dx    = r_dx;
   assign o_ball_dy    = r_dy;
   assign o_move_en    = r_move_en;
   assign o_ball_load  = r_ball_load;
   assign o_serve_side = r_serve_side;
   assign o_score1     = r_score1;
   assign o_score2     = r_score2;
   assign o_state      = r_state;

endmodule
